rgb_pwm_driver: RTL and testbench
=================================

// Module: rgb_pwm_driver
// PURPOSE
//  Consumer end of the 4-bit color-level interface: takes 4-bit R/G/B intensity codes
//  from the color-adjust logic and drives three PWM outputs to the board RGB LED.
//  Staged load with commit at PWM-period boundary (glitch-free); enable FSM drains cleanly.
// PARAMETERS
//  PRESCALE  default 195  clk cycles per PWM phase step (>=1); tick when prescaler==PRESCALE-1
//  PRE_W     default 8    prescaler width; must hold PRESCALE-1
// PORTS
//  clk          in   1  single system clock, all logic on posedge
//  reset        in   1  asynchronous, active-high reset
//  en           in   1  level; 1 = run PWM, 0 = stop after current period
//  load         in   1  one-cycle strobe: capture color_r/g/b into staging
//  color_r      in   4  red intensity code 0..15
//  color_g      in   4  green intensity code 0..15
//  color_b      in   4  blue intensity code 0..15
//  pending      out  1  staged value not yet committed to active duty
//  period_done  out  1  one-cycle pulse on last tick of each PWM period (phase 15->0)
//  pwm_r        out  1  registered red PWM
//  pwm_g        out  1  registered green PWM
//  pwm_b        out  1  registered blue PWM
// BEHAVIOUR
//  Reset: all outputs 0; state OFF; prescaler, phase, staging, active duty = 0.
//  FSM OFF: prescaler/phase held at 0, pwm_* = 0. en=1 -> RUN next cycle.
//  FSM RUN: prescaler counts 0..PRESCALE-1 and wraps; tick at terminal count.
//   4-bit phase advances on tick, wraps 15->0. en=0 -> DRAIN.
//  FSM DRAIN: keeps counting; at period end (tick with phase==15) -> OFF;
//   en=1 again during DRAIN -> back to RUN, no restart of counters.
//  Period end = tick && phase==15: period_done=1 for that cycle; if pending, active
//   duty <= staging and pending clears (same edge). Commits happen in RUN/DRAIN only.
//  load: staging <= {r,g,b}, pending <= 1, in any state. Multiple loads before commit:
//   last wins. load coincident with commit: old staging commits, new value captured,
//   pending stays 1. In OFF with pending, commit occurs at first period end after RUN.
//  pwm_x <= (state!=OFF) && (phase < duty_x); 1-cycle registered latency from phase.
//   duty 0 -> always low; duty 15 -> high 15 of 16 phases. No arithmetic overflow: compare only.
//  Reset mid-period: outputs drop to 0 asynchronously; staged value discarded.
// CONFIGURATION
//  RGB_PWM_GAMMA_EN defined: active duty is gamma-mapped at commit via 16-entry table
//   {0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15}; code 15 -> 15, code 7 -> 2.
//  Not defined: active duty = raw color code (linear).
// STRUCTURE
//  Package rgb_pwm_pkg: state enum {OFF, RUN, DRAIN}, PHASES=16, DUTY_W=4,
//   GAMMA_LUT constant array.
//  Sub-module prescale_tick (PRESCALE, PRE_W): counter + tick, with clear input held in OFF.
//  Top holds FSM, phase counter, staging/active registers, comparators.
// TESTING
//  Reset: assert reset mid-RUN with pwm_r=1 -> all outputs 0 immediately, state OFF.
//  PRESCALE=2, load r=4,g=0,b=15, en=1 -> after first commit pwm_r high 4 of 16 phases,
//   pwm_g never high, pwm_b high 15 of 16; period = 32 clk.
//  Load r=8 mid-period -> pwm_r unchanged until period_done, then 8/16; pending 1->0 there.
//  Two loads r=3 then r=9 before period end -> only r=9 committed.
//  load on same cycle as period_done -> old staging active, pending remains 1.
//  en=0 at phase 5 -> remains counting to phase 15, period_done, then OFF, pwm_* = 0.
//  With RGB_PWM_GAMMA_EN: load r=7 -> pwm_r high 2 of 16 phases.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared types, widths and the gamma table for the RGB PWM driver.
// Revision: 1.0
`default_nettype none

package rgb_pwm_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int PHASES = 16;
   localparam int DUTY_W = 4;

   localparam logic [DUTY_W-1:0] GAMMA_LUT [PHASES] = '{
      4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
      4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15
   };

   // Translates a staged color code into the duty value that becomes active at commit.
   function automatic logic [DUTY_W-1:0] map_duty(input logic [DUTY_W-1:0] code);
`ifdef RGB_PWM_GAMMA_EN
      return GAMMA_LUT[code];
`else
      return code;
`endif
   endfunction

endpackage

`default_nettype wire

// File: rtl/prescale_tick.sv
// prescale_tick: free-running prescaler producing one tick per PRESCALE clocks; held at 0 by i_clr.
// Revision: 1.0
`default_nettype none

module prescale_tick #(
   parameter int PRESCALE = 195,
   parameter int PRE_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick
);

   localparam logic [PRE_W-1:0] c_term = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] r_count;
   logic             w_at_term;

   assign w_at_term = (r_count == c_term);
   assign o_tick    = w_at_term && !i_clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr || w_at_term) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: 3-channel 16-phase PWM with staged color load committed at period end.
// Build option RGB_PWM_GAMMA_EN gamma-maps the duty at commit. Revision: 1.0
`default_nettype none

module rgb_pwm_driver
   import rgb_pwm_pkg::*;
#(
   parameter int PRESCALE = 195,
   parameter int PRE_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] color_r,
   input  logic [3:0] color_g,
   input  logic [3:0] color_b,
   output logic       pending,
   output logic       period_done,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b
);

   state_t              r_state;
   logic [DUTY_W-1:0]   r_phase;
   logic [DUTY_W-1:0]   r_stage_r, r_stage_g, r_stage_b;
   logic [DUTY_W-1:0]   r_duty_r, r_duty_g, r_duty_b;
   logic                r_pending;
   logic                r_pwm_r, r_pwm_g, r_pwm_b;
   logic                w_clr;
   logic                w_tick;
   logic                w_period_end;
   logic                w_commit;

   assign w_clr        = (r_state == ST_OFF);
   assign w_period_end = w_tick && (r_phase == DUTY_W'(PHASES - 1));
   assign w_commit     = w_period_end && r_pending;

   prescale_tick #(
      .PRESCALE (PRESCALE),
      .PRE_W    (PRE_W)
   ) u_prescale (
      .clk    (clk),
      .rst    (reset),
      .i_clr  (w_clr),
      .o_tick (w_tick)
   );

   // Ticks are gated off in OFF, so period end (and therefore commit) only occurs in RUN/DRAIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_OFF;
         r_phase <= '0;
      end else begin
         case (r_state)
            ST_OFF:   if (en) r_state <= ST_RUN;
            ST_RUN:   if (!en) r_state <= ST_DRAIN;
            ST_DRAIN: begin
               if (en)                r_state <= ST_RUN;
               else if (w_period_end) r_state <= ST_OFF;
            end
            default:  r_state <= ST_OFF;
         endcase

         if (w_clr)       r_phase <= '0;
         else if (w_tick) r_phase <= r_phase + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stage_r <= '0;
         r_stage_g <= '0;
         r_stage_b <= '0;
         r_duty_r  <= '0;
         r_duty_g  <= '0;
         r_duty_b  <= '0;
         r_pending <= 1'b0;
      end else begin
         if (w_commit) begin
            r_duty_r <= map_duty(r_stage_r);
            r_duty_g <= map_duty(r_stage_g);
            r_duty_b <= map_duty(r_stage_b);
         end
         // A load on the commit edge wins over the clear: the new value stays pending.
         if (load) begin
            r_stage_r <= color_r;
            r_stage_g <= color_g;
            r_stage_b <= color_b;
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pwm_r <= 1'b0;
         r_pwm_g <= 1'b0;
         r_pwm_b <= 1'b0;
      end else begin
         r_pwm_r <= !w_clr && (r_phase < r_duty_r);
         r_pwm_g <= !w_clr && (r_phase < r_duty_g);
         r_pwm_b <= !w_clr && (r_phase < r_duty_b);
      end
   end

   assign pending = r_pending;
   assign period_done = w_period_end;
   assign pwm_r = r_pwm_r;
   assign pwm_g = r_pwm_g;
   assign pwm_b = r_pwm_b;

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed stimulus with a per-period scoreboard of PWM high counts.
// Revision: 1.0
`default_nettype none

module tb_rgb_pwm_driver;

   localparam int PRESCALE = 2;
   localparam int PERIOD   = 16 * PRESCALE;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       load;
   logic [3:0] color_r, color_g, color_b;
   logic       pending, period_done, pwm_r, pwm_g, pwm_b;

   typedef struct {
      int r_hi;
      int g_hi;
      int b_hi;
      int pend;
      bit chk_len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int   gamma_tbl [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};

   rgb_pwm_driver #(
      .PRESCALE (PRESCALE),
      .PRE_W    (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .load        (load),
      .color_r     (color_r),
      .color_g     (color_g),
      .color_b     (color_b),
      .pending     (pending),
      .period_done (period_done),
      .pwm_r       (pwm_r),
      .pwm_g       (pwm_g),
      .pwm_b       (pwm_b)
   );

   always #5 clk = ~clk;

   function automatic int duty_of(input int code);
`ifdef RGB_PWM_GAMMA_EN
      return gamma_tbl[code];
`else
      return code;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Expected high-cycle counts for one whole period whose active duty codes are r/g/b.
   task automatic push_exp(input int r, input int g, input int b, input int pend, input bit chk_len);
      exp_t e;
      e.r_hi    = PRESCALE * duty_of(r);
      e.g_hi    = PRESCALE * duty_of(g);
      e.b_hi    = PRESCALE * duty_of(b);
      e.pend    = pend;
      e.chk_len = chk_len;
      exp_q.push_back(e);
   endtask

   task automatic wait_pd();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_done && n < 8 * PERIOD);
      if (!period_done) chk("period_done_timeout", 0, 1);
   endtask

   task automatic do_load(input int r, input int g, input int b);
      load    = 1'b1;
      color_r = 4'(r);
      color_g = 4'(g);
      color_b = 4'(b);
      @(negedge clk);
      load    = 1'b0;
   endtask

   // Monitor: accumulates PWM high cycles and scores each completed period.
   initial begin
      int cr = 0, cg = 0, cb = 0;
      int cyc = 0, last_pd = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            cr = 0; cg = 0; cb = 0;
         end else begin
            cr += int'(pwm_r);
            cg += int'(pwm_g);
            cb += int'(pwm_b);
            if (period_done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_period_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("period_r_high", cr, e.r_hi);
                  chk("period_g_high", cg, e.g_hi);
                  chk("period_b_high", cb, e.b_hi);
                  chk("period_pending", int'(pending), e.pend);
                  if (e.chk_len) chk("period_length", cyc - last_pd, PERIOD);
               end
               last_pd = cyc;
               cr = 0; cg = 0; cb = 0;
            end
         end
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; load = 1'b0;
      color_r = '0; color_g = '0; color_b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_pending", int'(pending), 0);
      chk("reset_period_done", int'(period_done), 0);
      chk("reset_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);

      do_load(4, 0, 15);
      chk("load_sets_pending", int'(pending), 1);
      push_exp(0, 0, 0, 1, 1'b0);
      push_exp(4, 0, 15, 0, 1'b1);
      en = 1'b1;
      wait_pd();
      wait_pd();

      // Mid-period load holds off until the period boundary.
      push_exp(4, 0, 15, 1, 1'b1);
      push_exp(8, 0, 15, 0, 1'b1);
      repeat (10) @(negedge clk);
      do_load(8, 0, 15);
      chk("midload_pending", int'(pending), 1);
      wait_pd();
      @(negedge clk);
      chk("commit_clears_pending", int'(pending), 0);
      wait_pd();

      // Two loads before the boundary: the last one wins.
      push_exp(8, 0, 15, 1, 1'b1);
      push_exp(9, 0, 15, 0, 1'b1);
      repeat (4) @(negedge clk);
      do_load(3, 0, 15);
      do_load(9, 0, 15);
      wait_pd();
      wait_pd();

      // Load on the same cycle as period_done.
      push_exp(9, 0, 15, 1, 1'b1);
      repeat (4) @(negedge clk);
      do_load(5, 0, 15);
      wait_pd();
      push_exp(5, 0, 15, 1, 1'b1);
      push_exp(11, 0, 15, 0, 1'b1);
      do_load(11, 0, 15);
      chk("coincident_load_pending", int'(pending), 1);
      wait_pd();
      wait_pd();

      // Drop enable around phase 5: the period completes, then the block stops.
      push_exp(11, 0, 15, 0, 1'b1);
      repeat (11) @(negedge clk);
      en = 1'b0;
      wait_pd();
      repeat (40) @(negedge clk);
      chk("drain_off_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
      chk("drain_off_period_done", int'(period_done), 0);

      // Load while OFF stays pending until the first period end after restart.
      do_load(7, 0, 15);
      repeat (5) @(negedge clk);
      chk("off_load_pending", int'(pending), 1);
      push_exp(11, 0, 15, 1, 1'b0);
      push_exp(7, 0, 15, 0, 1'b1);
      en = 1'b1;
      wait_pd();
      wait_pd();

      // Asynchronous reset while pwm_r is high; staged value must be discarded.
      load = 1'b1; color_r = 4'd12; color_g = 4'd12; color_b = 4'd12;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      chk("pre_reset_pwm_r", int'(pwm_r), 1);
      chk("pre_reset_pending", int'(pending), 1);
      #2;
      reset = 1'b1;
      en = 1'b0;
      #1;
      chk("async_reset_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
      chk("async_reset_pending", int'(pending), 0);
      @(negedge clk);
      reset = 1'b0;
      push_exp(0, 0, 0, 0, 1'b0);
      push_exp(0, 0, 0, 0, 1'b1);
      en = 1'b1;
      wait_pd();
      en = 1'b0;
      wait_pd();
      repeat (40) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
